// File: rtl/dffsr_async_ctl_seq_if.sv
// rtl/dffsr_async_ctl_seq_if.sv - clear/preset command handshake for dffsr_async_ctl_seq
//
// Purpose: carries one clear/preset command from a requester to the sequencer.
// Signals:
//   req_valid  requester -> sequencer  command valid, held until accepted
//   req_ready  sequencer -> requester  command taken when valid & ready at a rising edge
//   req_val    requester -> sequencer  0 = clear (pulse RN), 1 = preset (pulse SN)
//   req_len    requester -> sequencer  pulse width in cycles, 0 treated as 1
interface dffsr_async_ctl_seq_if #(
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_val;
  logic [CW-1:0] req_len;

  modport master (output req_valid, output req_val, output req_len, input req_ready);
  modport slave  (input req_valid, input req_val, input req_len, output req_ready);
endinterface

// File: rtl/dffsr_async_ctl_seq.sv
// rtl/dffsr_async_ctl_seq.sv - sequencer driving RN/SN/CEN of a dffsr bank
//
// Purpose: turns clear/preset commands into a glitch-free active-low RN or SN
// pulse of programmable width, with the target clock enable held low from one
// cycle before the pulse until REC cycles after it is released.
// Parameters:
//   CW   width of the pulse-length field and pulse counter
//   REC  recovery cycles (>= 1) between pin release and clock-enable restore
// Ports:
//   clk_i    clock, all state changes on rising edge
//   rst_i    synchronous active-high reset
//   req      command handshake (slave side)
//   abort_i  end the current SETUP/PULSE early; recovery still runs
//   rn_o     active-low clear to target flops (flop output)
//   sn_o     active-low preset to target flops (flop output)
//   cen_o    clock enable for target flops
//   busy_o   high from the cycle after acceptance through the DONE cycle
//   done_o   one-cycle completion pulse
module dffsr_async_ctl_seq #(
  parameter int CW  = 4,
  parameter int REC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  dffsr_async_ctl_seq_if.slave     req,
  input  logic                     abort_i,
  output logic                     rn_o,
  output logic                     sn_o,
  output logic                     cen_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int RW = (REC > 1) ? $clog2(REC) : 1;
  localparam logic [RW-1:0] REC_LAST = RW'(REC - 1);
  localparam logic [CW-1:0] LEN_ONE  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_RECOV, S_FIN} state_e;

  state_e        state_q, state_d;
  logic          go_q, go_d;
  logic          val_q, val_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rec_q, rec_d;
  logic          ready_q, ready_d;
  logic          rn_q, rn_d;
  logic          sn_q, sn_d;
  logic          cen_q, cen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  assign accept = req.req_valid & ready_q;

  always_comb begin
    state_d = state_q;
    go_d    = accept;
    val_d   = val_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;

    if (accept) begin
      val_d = req.req_val;
      len_d = (req.req_len == '0) ? LEN_ONE : req.req_len;
    end

    // go_q delays SETUP by one cycle after acceptance, so the command
    // fields are stable in len_q/val_q before the counter loads from them.
    case (state_q)
      S_IDLE: begin
        if (go_q) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (abort_i) begin
          state_d = S_RECOV;
          rec_d   = REC_LAST;
        end else begin
          state_d = S_PULSE;
          cnt_d   = len_q - LEN_ONE;
        end
      end
      S_PULSE: begin
        if (abort_i || cnt_q == '0) begin
          state_d = S_RECOV;
          rec_d   = REC_LAST;
        end else begin
          cnt_d = cnt_q - LEN_ONE;
        end
      end
      S_RECOV: begin
        if (rec_q == '0) state_d = S_FIN;
        else             rec_d   = rec_q - RW'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so every pin
    // is a plain flop output that changes on the same edge as the state.
    // val_q is a single bit, so RN and SN can never be low together.
    ready_d = (state_d == S_IDLE) && !accept;
    busy_d  = accept || (state_d != S_IDLE);
    cen_d   = !((state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_RECOV));
    rn_d    = !((state_d == S_PULSE) && !val_q);
    sn_d    = !((state_d == S_PULSE) &&  val_q);
    done_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      val_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      rec_q   <= '0;
      ready_q <= 1'b0;
      rn_q    <= 1'b1;
      sn_q    <= 1'b1;
      cen_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      val_q   <= val_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
      ready_q <= ready_d;
      rn_q    <= rn_d;
      sn_q    <= sn_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req.req_ready = ready_q;
  assign rn_o          = rn_q;
  assign sn_o          = sn_q;
  assign cen_o         = cen_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_dffsr_async_ctl_seq.sv
// tb/tb_dffsr_async_ctl_seq.sv - self-checking bench for dffsr_async_ctl_seq
module tb_dffsr_async_ctl_seq;
  localparam int CW  = 4;
  localparam int REC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic rn, sn, cen, busy, done;

  dffsr_async_ctl_seq_if #(.CW(CW)) req_if ();

  dffsr_async_ctl_seq #(.CW(CW), .REC(REC)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req     (req_if.slave),
    .abort_i (abort),
    .rn_o    (rn),
    .sn_o    (sn),
    .cen_o   (cen),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Reference model: on acceptance the whole remaining output timeline is
  // queued as one record per clock edge; ABORT rewrites the tail.
  typedef enum {K_IDLE, K_RST, K_GO, K_SETUP, K_PULSE, K_RECOV, K_FIN} kind_e;
  typedef struct {
    kind_e kind;
    logic  rn, sn, cen, busy, done, ready;
  } obs_t;

  obs_t mq[$];
  obs_t cur;
  int   mlen;

  function automatic obs_t mk(input kind_e k, input logic v);
    obs_t o;
    o.kind = k; o.rn = 1'b1; o.sn = 1'b1; o.cen = 1'b1;
    o.busy = 1'b1; o.done = 1'b0; o.ready = 1'b0;
    case (k)
      K_IDLE:           begin o.busy = 1'b0; o.ready = 1'b1; end
      K_RST:            o.busy = 1'b0;
      K_SETUP, K_RECOV: o.cen = 1'b0;
      K_PULSE:          begin o.cen = 1'b0; if (v) o.sn = 1'b0; else o.rn = 1'b0; end
      K_FIN:            o.done = 1'b1;
      default:          ;
    endcase
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      cur = mk(K_RST, 1'b0);
    end else if (mq.size() > 0) begin
      if (abort && (cur.kind == K_SETUP || cur.kind == K_PULSE)) begin
        mq.delete();
        repeat (REC) mq.push_back(mk(K_RECOV, 1'b0));
        mq.push_back(mk(K_FIN, 1'b0));
      end
      cur = mq.pop_front();
    end else if (cur.ready && req_if.req_valid) begin
      mlen = (req_if.req_len == '0) ? 1 : int'(req_if.req_len);
      cur = mk(K_GO, 1'b0);
      mq.push_back(mk(K_SETUP, 1'b0));
      repeat (mlen) mq.push_back(mk(K_PULSE, req_if.req_val));
      repeat (REC) mq.push_back(mk(K_RECOV, 1'b0));
      mq.push_back(mk(K_FIN, 1'b0));
    end else begin
      cur = mk(K_IDLE, 1'b0);
    end
    #1;
    chk("model_rn",    rn,              cur.rn);
    chk("model_sn",    sn,              cur.sn);
    chk("model_cen",   cen,             cur.cen);
    chk("model_busy",  busy,            cur.busy);
    chk("model_done",  done,            cur.done);
    chk("model_ready", req_if.req_ready, cur.ready);
    chk("rn_sn_never_both_low", rn | sn, 1);
  end

  typedef struct {
    logic val;
    int   len;
    int   abort_at;   // edge after acceptance at which ABORT is sampled, 0 = none
    int   exp_rn;     // cycles RN low
    int   exp_sn;     // cycles SN low
    int   exp_cen;    // cycles CEN low
    int   exp_done;   // edges from acceptance to DONE
  } vec_t;

  vec_t vt[7];

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_if.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " ready_wait"}, req_if.req_ready, 1);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int rl = 0, sl = 0, cl = 0, dat = -1, dn = 0, first_low = -1, busy_bad = 0;
    wait_ready(tag);
    req_if.req_valid = 1'b1;
    req_if.req_val   = v.val;
    req_if.req_len   = CW'(v.len);
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    chk({tag, " ready_after_accept"}, req_if.req_ready, 0);
    chk({tag, " busy_after_accept"}, busy, 1);
    for (int rel = 1; rel <= 40; rel++) begin
      abort = (rel == v.abort_at);
      @(posedge clk); #1;
      abort = 1'b0;
      if (!rn)  rl++;
      if (!sn)  sl++;
      if (!cen) cl++;
      if ((!rn || !sn) && first_low < 0) first_low = rel;
      if (done) begin dn++; if (dat < 0) dat = rel; end
      if (dat < 0 && !busy) busy_bad++;
    end
    chk({tag, " rn_low_cycles"},  rl,  v.exp_rn);
    chk({tag, " sn_low_cycles"},  sl,  v.exp_sn);
    chk({tag, " cen_low_cycles"}, cl,  v.exp_cen);
    chk({tag, " done_latency"},   dat, v.exp_done);
    chk({tag, " done_count"},     dn,  1);
    chk({tag, " pulse_start"},    first_low, (v.exp_rn + v.exp_sn > 0) ? 2 : -1);
    chk({tag, " busy_gap"},       busy_bad, 0);
  endtask

  initial begin
    int acc, dn;
    logic a;

    vt[0] = '{1'b0,  3, 0, 3,  0,  6,  7};  // clear len 3
    vt[1] = '{1'b1,  0, 0, 0,  1,  4,  5};  // preset, len 0 acts as 1
    vt[2] = '{1'b0, 15, 6, 4,  0,  7,  8};  // abort on 4th pulse cycle
    vt[3] = '{1'b0,  5, 2, 0,  0,  3,  4};  // abort during SETUP
    vt[4] = '{1'b1, 15, 0, 0, 15, 18, 19};  // maximum length preset
    vt[5] = '{1'b0,  1, 0, 1,  0,  4,  5};  // clear len 1
    vt[6] = '{1'b0,  2, 5, 2,  0,  5,  6};  // abort in RECOV is ignored

    req_if.req_valid = 1'b0;
    req_if.req_val   = 1'b0;
    req_if.req_len   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rn",    rn,   1);
    chk("reset_sn",    sn,   1);
    chk("reset_cen",   cen,  1);
    chk("reset_busy",  busy, 0);
    chk("reset_done",  done, 0);
    chk("reset_ready", req_if.req_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", req_if.req_ready, 1);

    for (int i = 0; i < 7; i++) run_cmd(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a pulse.
    wait_ready("rst_mid");
    req_if.req_valid = 1'b1; req_if.req_val = 1'b0; req_if.req_len = CW'(8);
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid pulse_active", rn, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid rn",    rn,   1);
    chk("rst_mid sn",    sn,   1);
    chk("rst_mid cen",   cen,  1);
    chk("rst_mid busy",  busy, 0);
    chk("rst_mid ready", req_if.req_ready, 0);
    chk("rst_mid done",  done, 0);
    dn = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dn++; end
    chk("rst_mid no_done", dn, 0);
    run_cmd(vt[0], "post_rst");

    // REQ_VALID held high, REQ_VAL flipped after every acceptance.
    // One command with len 2 occupies len+REC+4 = 8 edges, so 40 edges see 5 accepts.
    wait_ready("held");
    req_if.req_val = 1'b0; req_if.req_len = CW'(2); req_if.req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      a = req_if.req_ready;
      @(posedge clk); #1;
      if (a) begin acc++; req_if.req_val = ~req_if.req_val; end
    end
    req_if.req_valid = 1'b0;
    chk("held accept_count", acc, 5);

    // Randomized traffic, checked by the reference model every edge.
    for (int i = 0; i < 400; i++) begin
      req_if.req_valid = ($urandom_range(0, 1) == 1);
      req_if.req_val   = 1'($urandom_range(0, 1));
      req_if.req_len   = CW'($urandom_range(0, 15));
      abort            = ($urandom_range(0, 9) == 0);
      rst              = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; abort = 1'b0; req_if.req_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dffsr_async_ctl_seq.md
# dffsr_async_ctl_seq

Synchronous sequencer that drives the active-low asynchronous clear (RN) and preset (SN) pins of a bank of set/reset flip-flops from single-clock logic. It accepts clear/preset commands over a valid/ready handshake. It generates a glitch-free RN or SN pulse of programmable width and holds the target flops' clock enable low across the pulse and a recovery window. This keeps removal/recovery and minimum-width constraints on the cells met by construction. It sits between the control FSMs and any bank of dffsr_1 cells that needs run-time clearing or presetting.

## Interface
- CW, 4: width of pulse-length field and internal width counter.
- REC, 2: recovery cycles (≥1) between control release and clock-enable restore.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when REQ_VALID & REQ_READY at a rising edge.
- REQ_VAL  in  1  0 = clear (pulse RN), 1 = preset (pulse SN); sampled at acceptance.
- REQ_LEN  in  CW  pulse width in cycles; 0 treated as 1; sampled at acceptance.
- ABORT  in  1  terminate current pulse early; recovery still enforced.
- RN  out  1  active-low clear to target flops; driven directly from a flop.
- SN  out  1  active-low preset to target flops; driven directly from a flop.
- CEN  out  1  clock enable for target flops; low while control pins are active or recovering.
- BUSY  out  1  high from the cycle after acceptance through the DONE cycle.
- DONE  out  1  one-cycle pulse when the command is complete.

## Operation
- States: IDLE, SETUP, PULSE, RECOV, FIN.
- IDLE: REQ_READY=1, CEN=1, RN=SN=1. On accept, latch REQ_VAL and len=max(REQ_LEN,1). Go to SETUP.
- SETUP (1 cycle): CEN=0, RN=SN=1. This guarantees no target clock edge coincides with control assertion. Go to PULSE. If ABORT, go to RECOV instead, and no pulse is issued.
- PULSE (len cycles): RN=0 if clear, SN=0 if preset; CEN=0. Counter loads len-1 and decrements. At 0 go to RECOV. ABORT releases the pin on the next edge and goes to RECOV.
- RECOV (REC cycles): RN=SN=1, CEN=0. Then go to FIN.
- FIN (1 cycle): DONE=1, CEN=1, REQ_READY=0. Then go to IDLE.
- REQ_READY=1 only in IDLE. REQ_VALID while not ready is held by the requester, not dropped. A new command is accepted at the earliest on the cycle after FIN.
- Invariant: RN and SN are never both 0, in any state, including during and after reset.
- ABORT in IDLE, RECOV or FIN is ignored.
- Len = 2^CW-1 is the maximum; the counter never wraps.

## Timing
- All outputs registered. Reset values (RST high at an edge): RN=1, SN=1, CEN=1, BUSY=0, DONE=0, REQ_READY=0, state=IDLE. REQ_READY=1 from the first edge after RST deasserts.
- Accept at edge t. At t+1: SETUP, BUSY=1, CEN=0. Edges t+2 .. t+1+len: RN/SN low. Edges t+2+len .. t+1+len+REC: RECOV. At t+2+len+REC: FIN, DONE=1, CEN=1. At t+3+len+REC: IDLE.
- Total latency from acceptance to DONE is len+REC+2 cycles.
- RST mid-operation: RN/SN return high and CEN returns 1 at the same edge. The recovery window is skipped; the system reset covers it. No DONE is produced.
- ABORT sampled in PULSE at edge e: pin high at e, RECOV runs REC full cycles from e.

## Test plan
- Reset, then clear with REQ_LEN=3, REC=2: RN low exactly 3 cycles starting 2 edges after accept. SN stays 1. CEN low for 6 cycles. DONE at accept+7 for one cycle.
- Preset with REQ_LEN=0: SN low exactly 1 cycle. RN stays 1. DONE at accept+5.
- REQ_VALID held high continuously with alternating REQ_VAL: accepts only in IDLE, never overlapping. RN and SN are never both 0 (assertion every cycle).
- Clear with REQ_LEN=15, ABORT asserted on the 4th pulse cycle: RN low 4 cycles. RECOV lasts exactly REC cycles after ABORT. DONE follows.
- ABORT during SETUP: no RN/SN pulse. CEN low for 1+REC cycles. DONE is still issued.
- RST asserted during PULSE: at the same edge RN=SN=1, CEN=1, BUSY=0, REQ_READY=0. No DONE. The next command after reset completes normally.
